// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserialiser with bit-count framing,
// a registered word output and a one-cycle completion strobe.
module sipo_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  localparam int unsigned CNT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             shift,
  input  logic             clear,
  output logic [WIDTH-1:0] parallel_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sr_shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             last_bit;

  // Bit-order selection: where a newly captured bit enters the register
  if (LSB_FIRST) begin : g_lsb_first
    assign sr_shifted = {serial_in, sr_q[WIDTH-1:1]};
  end else begin : g_msb_first
    assign sr_shifted = {sr_q[WIDTH-2:0], serial_in};
  end

  assign last_bit = (cnt_q == LAST_CNT);

  // Next-state: clear beats shift; completion snapshots the post-shift word
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift) begin
      sr_d = sr_shifted;
      if (last_bit) begin
        cnt_d   = '0;
        dout_d  = sr_shifted;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign parallel_out = sr_q;
  assign data_out     = dout_q;
  assign data_valid   = valid_q;
  assign bit_count    = cnt_q;
  assign busy         = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: three configurations (8/LSB, 8/MSB,
// 12/LSB) share stimulus and are compared against a bit-history model.
module tb_sipo_deser;

  logic clk = 1'b0;
  logic rst_n, serial_in, shift, clear;

  logic [7:0]  po0, do0, po1, do1;
  logic [2:0]  bc0, bc1;
  logic        dv0, dv1, bz0, bz1;
  logic [11:0] po2, do2;
  logic [3:0]  bc2;
  logic        dv2, bz2;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .LSB_FIRST(1'b1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .shift(shift), .clear(clear),
    .parallel_out(po0), .data_out(do0), .data_valid(dv0), .busy(bz0), .bit_count(bc0));
  sipo_deser #(.WIDTH(8), .LSB_FIRST(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .shift(shift), .clear(clear),
    .parallel_out(po1), .data_out(do1), .data_valid(dv1), .busy(bz1), .bit_count(bc1));
  sipo_deser #(.WIDTH(12), .LSB_FIRST(1'b1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .shift(shift), .clear(clear),
    .parallel_out(po2), .data_out(do2), .data_valid(dv2), .busy(bz2), .bit_count(bc2));

  // Reference model: history of accepted bits since last clear/reset
  int   mw[3] = '{8, 8, 12};
  bit   ml[3] = '{1'b1, 1'b0, 1'b1};
  bit   hist[3][$];
  int   m_cnt[3];
  logic [31:0] m_dout[3];
  bit   m_valid[3];

  // Live word: bit received j edges ago sits at W-1-j (LSB first) or j (MSB first)
  function automatic logic [31:0] pout(int k);
    logic [31:0] v = '0;
    int n = hist[k].size();
    for (int j = 0; j < n && j < mw[k]; j++) begin
      if (ml[k]) v[mw[k]-1-j] = hist[k][n-1-j];
      else       v[j]         = hist[k][n-1-j];
    end
    return v;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        hist[k].delete(); m_cnt[k] = 0; m_dout[k] = '0; m_valid[k] = 1'b0;
      end else if (clear) begin
        hist[k].delete(); m_cnt[k] = 0; m_valid[k] = 1'b0;
      end else if (shift) begin
        hist[k].push_back(serial_in);
        if (hist[k].size() > 32) void'(hist[k].pop_front());
        m_cnt[k] = (m_cnt[k] + 1) % mw[k];
        m_valid[k] = (m_cnt[k] == 0);
        if (m_cnt[k] == 0) m_dout[k] = pout(k);
      end else begin
        m_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("d0.parallel_out", 32'(po0), pout(0));
    chk("d0.data_out",     32'(do0), m_dout[0]);
    chk("d0.data_valid",   32'(dv0), 32'(m_valid[0]));
    chk("d0.bit_count",    32'(bc0), 32'(m_cnt[0]));
    chk("d0.busy",         32'(bz0), 32'(m_cnt[0] != 0));
    chk("d1.parallel_out", 32'(po1), pout(1));
    chk("d1.data_out",     32'(do1), m_dout[1]);
    chk("d1.data_valid",   32'(dv1), 32'(m_valid[1]));
    chk("d1.bit_count",    32'(bc1), 32'(m_cnt[1]));
    chk("d1.busy",         32'(bz1), 32'(m_cnt[1] != 0));
    chk("d2.parallel_out", 32'(po2), pout(2));
    chk("d2.data_out",     32'(do2), m_dout[2]);
    chk("d2.data_valid",   32'(dv2), 32'(m_valid[2]));
    chk("d2.bit_count",    32'(bc2), 32'(m_cnt[2]));
    chk("d2.busy",         32'(bz2), 32'(m_cnt[2] != 0));
  endtask

  // One clock: model and DUT update on the edge, outputs sampled 1 ns later
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic send_bits(input logic [31:0] val, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      rst_n = 1'b1; clear = 1'b0; shift = 1'b1; serial_in = val[i];
      step();
      shift = 1'b0;
      if (i < nbits - 1)
        for (int g = 0; g < gap; g++) step();
    end
    shift = 1'b0;
  endtask

  task automatic idle(input int n);
    shift = 1'b0; clear = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic       rst_n, clr, sh, si;
    int         exp_cnt;
    logic       exp_valid;
    logic [7:0] exp_lsb, exp_msb;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Reset with shift active, then 1,0,0,0,1,1,1,1 -> F1 (LSB first) / 8F (MSB first)
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b0, 8'h00, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0, 8'h00, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5, 1'b0, 8'h00, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 6, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 7, 1'b0, 8'h00, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 8'hF1, 8'h8F};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'hF1, 8'h8F};

    rst_n = 1'b0; clear = 1'b0; shift = 1'b1; serial_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_dout[k] = '0; m_valid[k] = 1'b0;
    end

    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rst_n; clear = tbl[i].clr; shift = tbl[i].sh; serial_in = tbl[i].si;
      step();
      chk($sformatf("tbl[%0d].d0.bit_count", i), 32'(bc0), 32'(tbl[i].exp_cnt));
      chk($sformatf("tbl[%0d].d0.data_valid", i), 32'(dv0), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl[%0d].d0.data_out", i), 32'(do0), 32'(tbl[i].exp_lsb));
      chk($sformatf("tbl[%0d].d1.data_valid", i), 32'(dv1), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl[%0d].d1.data_out", i), 32'(do1), 32'(tbl[i].exp_msb));
    end

    // Back-to-back: A5 then 3C with shift held high for 16 edges
    send_bits(32'hA5, 8, 0);
    chk("b2b.first.valid", 32'(dv0), 32'd1);
    chk("b2b.first.data",  32'(do0), 32'hA5);
    send_bits(32'h3C, 8, 0);
    chk("b2b.second.valid", 32'(dv0), 32'd1);
    chk("b2b.second.data",  32'(do0), 32'h3C);
    idle(2);

    // Gapped: three idle cycles between every bit
    send_bits(32'hA5, 8, 3);
    chk("gap.first.valid", 32'(dv0), 32'd1);
    chk("gap.first.data",  32'(do0), 32'hA5);
    idle(3);
    send_bits(32'h3C, 8, 3);
    chk("gap.second.valid", 32'(dv0), 32'd1);
    chk("gap.second.data",  32'(do0), 32'h3C);
    idle(2);

    // Clear mid-word together with shift
    send_bits(32'h1F, 5, 0);
    clear = 1'b1; shift = 1'b1; serial_in = 1'b1;
    step();
    clear = 1'b0; shift = 1'b0;
    chk("clr.bit_count",    32'(bc0), 32'd0);
    chk("clr.busy",         32'(bz0), 32'd0);
    chk("clr.parallel_out", 32'(po0), 32'd0);
    chk("clr.data_out",     32'(do0), 32'h3C);
    chk("clr.data_valid",   32'(dv0), 32'd0);
    send_bits(32'h96, 8, 0);
    chk("clr.next.valid", 32'(dv0), 32'd1);
    chk("clr.next.data",  32'(do0), 32'h96);
    idle(1);

    // Reset mid-word, then a 12-bit word
    send_bits(32'h7, 3, 0);
    rst_n = 1'b0; shift = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst.d0.data_out",   32'(do0), 32'd0);
    chk("rst.d0.data_valid", 32'(dv0), 32'd0);
    chk("rst.d2.data_out",   32'(do2), 32'd0);
    chk("rst.d2.bit_count",  32'(bc2), 32'd0);
    send_bits(32'h055, 12, 0);
    chk("w12.valid", 32'(dv2), 32'd1);
    chk("w12.data",  32'(do2), 32'h055);
    idle(1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      shift     = ($urandom_range(0, 3) != 0);
      serial_in = 1'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
